// File: rtl/dispense_pkg.sv
// Shared types and defaults for the dispense scheduler: FSM state encoding,
// default watchdog/gap settings and a counter-width helper.
package dispense_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_RUN   = 3'd2,
        S_ACK   = 3'd3,
        S_GAP   = 3'd4,
        S_FAULT = 3'd5
    } state_e;

    localparam int DEF_TIMEOUT = 50000;
    localparam int DEF_GAP     = 4;

    // Width of a counter that must hold values 0 .. n-1 (at least one bit).
    function automatic int cnt_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/dispense_sched_rr_pick.sv
// Combinational round-robin picker: returns the first set request found
// searching upward from ptr_i+1, wrapping modulo N_REQ.
module rr_pick #(
    parameter int N_REQ = 2,
    parameter int IDW   = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [IDW-1:0]   ptr_i,
    output logic             valid_o,
    output logic [IDW-1:0]   idx_o
);

    logic           above_hit;
    logic [IDW-1:0] above_idx;
    logic [IDW-1:0] any_idx;

    // Scanning from the top down leaves the lowest matching index in each
    // variable: lowest request above the pointer, else lowest request overall.
    always_comb begin
        // NOTE: every variable gets a default before the loop so no path
        // leaves it unassigned; otherwise synthesis infers a latch.
        above_hit = 1'b0;
        above_idx = '0;
        any_idx   = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                any_idx = IDW'(i);
                if (IDW'(i) > ptr_i) begin
                    above_hit = 1'b1;
                    above_idx = IDW'(i);
                end
            end
        end
    end

    assign valid_o = |req_i;
    assign idx_o   = above_hit ? above_idx : any_idx;

endmodule

// File: rtl/dispense_sched.sv
// Round-robin dispense scheduler sharing one emitter channel between N_REQ
// requesters, with a RUN watchdog and an emergency-stop fault path.
module dispense_sched
    import dispense_pkg::*;
#(
    parameter int N_REQ   = 2,
    parameter int AMT_W   = 8,
    parameter int TO_W    = 16,
    parameter int TIMEOUT = DEF_TIMEOUT,
    parameter int GAP     = DEF_GAP
) (
    input  logic                       clk,
    input  logic                       RESET,
    input  logic [N_REQ-1:0]           req,
    input  logic [N_REQ*AMT_W-1:0]     amount,
    input  logic                       emit_done,
    input  logic                       estop,
    input  logic                       fault_clr,
    output logic                       load1,
    output logic [AMT_W-1:0]           emit_amt,
    output logic                       out_ctrl,
    output logic [N_REQ-1:0]           ack,
    output logic [$clog2(N_REQ)-1:0]   grant_id,
    output logic                       busy,
    output logic                       fault
);

    localparam int IDW = $clog2(N_REQ);
    localparam int GW  = cnt_w(GAP);

    state_e             state_q;
    logic [IDW-1:0]     ptr_q;
    logic [IDW-1:0]     grant_id_q;
    logic [AMT_W-1:0]   amt_q;
    logic [AMT_W-1:0]   emit_amt_q;
    logic [TO_W-1:0]    wd_q;
    logic [TO_W-1:0]    wd_d;
    logic [GW-1:0]      gap_q;
    logic [GW-1:0]      gap_d;
    logic               load1_q;
    logic               out_ctrl_q;
    logic [N_REQ-1:0]   ack_q;
    logic               busy_q;
    logic               fault_q;

    logic               pick_valid;
    logic [IDW-1:0]     pick_idx;
    logic [AMT_W-1:0]   pick_amt;
    logic               wd_last;
    logic               gap_last;

    rr_pick #(
        .N_REQ (N_REQ),
        .IDW   (IDW)
    ) u_pick (
        .req_i   (req),
        .ptr_i   (ptr_q),
        .valid_o (pick_valid),
        .idx_o   (pick_idx)
    );

    always_comb begin
        pick_amt = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (pick_idx == IDW'(i)) begin
                pick_amt = amount[i*AMT_W +: AMT_W];
            end
        end
    end

    assign wd_d     = wd_q + 1'b1;
    assign gap_d    = gap_q + 1'b1;
    assign wd_last  = (wd_q == TO_W'(TIMEOUT - 1));
    assign gap_last = (gap_q == GW'(GAP - 1));

    // Every output is a flop updated on the transition that enters the state
    // it belongs to, so no input reaches an output combinationally.
    always_ff @(posedge clk) begin
        if (!RESET) begin
            state_q    <= S_IDLE;
            ptr_q      <= IDW'(N_REQ - 1);
            grant_id_q <= '0;
            amt_q      <= '0;
            emit_amt_q <= '0;
            wd_q       <= '0;
            gap_q      <= '0;
            load1_q    <= 1'b0;
            out_ctrl_q <= 1'b0;
            ack_q      <= '0;
            busy_q     <= 1'b0;
            fault_q    <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments only; the
            // pulse outputs default low here and are raised by one branch below.
            load1_q    <= 1'b0;
            emit_amt_q <= '0;
            ack_q      <= '0;

            unique case (state_q)
                S_IDLE: begin
                    if (!estop && pick_valid) begin
                        grant_id_q <= pick_idx;
                        amt_q      <= pick_amt;
                        busy_q     <= 1'b1;
                        if (pick_amt == '0) begin
                            // Nothing to dispense: acknowledge without touching the emitter.
                            state_q <= S_ACK;
                            ack_q   <= N_REQ'(1) << pick_idx;
                        end else begin
                            state_q <= S_LOAD;
                        end
                    end
                end

                S_LOAD: begin
                    load1_q    <= 1'b1;
                    emit_amt_q <= amt_q;
                    out_ctrl_q <= 1'b1;
                    wd_q       <= '0;
                    state_q    <= S_RUN;
                end

                S_RUN: begin
                    wd_q <= wd_d;
                    if (estop) begin
                        state_q    <= S_FAULT;
                        out_ctrl_q <= 1'b0;
                        fault_q    <= 1'b1;
                    end else if (emit_done) begin
                        state_q    <= S_ACK;
                        out_ctrl_q <= 1'b0;
                        ack_q      <= N_REQ'(1) << grant_id_q;
                    end else if (wd_last) begin
                        state_q    <= S_FAULT;
                        out_ctrl_q <= 1'b0;
                        fault_q    <= 1'b1;
                    end
                end

                S_ACK: begin
                    ptr_q   <= grant_id_q;
                    gap_q   <= '0;
                    state_q <= S_GAP;
                end

                S_GAP: begin
                    if (gap_last) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        gap_q <= gap_d;
                    end
                end

                S_FAULT: begin
                    // Pointer is left alone so the interrupted requester keeps priority.
                    if (fault_clr && !estop) begin
                        state_q <= S_IDLE;
                        fault_q <= 1'b0;
                        busy_q  <= 1'b0;
                    end
                end

                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign load1    = load1_q;
    assign emit_amt = emit_amt_q;
    assign out_ctrl = out_ctrl_q;
    assign ack      = ack_q;
    assign grant_id = grant_id_q;
    assign busy     = busy_q;
    assign fault    = fault_q;

endmodule

// File: tb/tb_dispense_sched.sv
// Randomised scoreboard bench for dispense_sched: a transaction-level
// round-robin model predicts load/ack events; directed checks cover timing and faults.
module tb_dispense_sched;

    localparam int N_REQ   = 2;
    localparam int AMT_W   = 8;
    localparam int TO_W    = 16;
    localparam int TIMEOUT = 20;
    localparam int GAP     = 4;

    typedef struct {
        bit is_load;
        int id;
        int amt;
    } exp_t;

    logic                       clk;
    logic                       RESET;
    logic [N_REQ-1:0]           req;
    logic [N_REQ*AMT_W-1:0]     amount;
    logic                       emit_done;
    logic                       estop;
    logic                       fault_clr;
    logic                       load1;
    logic [AMT_W-1:0]           emit_amt;
    logic                       out_ctrl;
    logic [N_REQ-1:0]           ack;
    logic [$clog2(N_REQ)-1:0]   grant_id;
    logic                       busy;
    logic                       fault;

    int   compared   = 0;
    int   mismatched = 0;
    int   cyc        = 0;
    int   model_ptr  = N_REQ - 1;
    bit   emitter_on = 1'b1;
    int   amt_tb[N_REQ];
    exp_t exp_q[$];

    dispense_sched #(
        .N_REQ   (N_REQ),
        .AMT_W   (AMT_W),
        .TO_W    (TO_W),
        .TIMEOUT (TIMEOUT),
        .GAP     (GAP)
    ) dut (
        .clk       (clk),
        .RESET     (RESET),
        .req       (req),
        .amount    (amount),
        .emit_done (emit_done),
        .estop     (estop),
        .fault_clr (fault_clr),
        .load1     (load1),
        .emit_amt  (emit_amt),
        .out_ctrl  (out_ctrl),
        .ack       (ack),
        .grant_id  (grant_id),
        .busy      (busy),
        .fault     (fault)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL global_timeout: got no finish, required finish (compared=%0d)", compared);
        $fatal(1, "global timeout");
    end

    task automatic check(input string name, input longint act, input longint exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_exp(input bit is_load, input int id, input int amt);
        exp_t e;
        e.is_load = is_load;
        e.id      = id;
        e.amt     = amt;
        exp_q.push_back(e);
    endtask

    // Reference arbitration: first requester after the last winner, cyclically.
    function automatic int next_winner(input logic [N_REQ-1:0] m, input int p);
        for (int d = 1; d <= N_REQ; d++) begin
            if (m[(p + d) % N_REQ]) return (p + d) % N_REQ;
        end
        return -1;
    endfunction

    task automatic apply_amounts();
        for (int i = 0; i < N_REQ; i++) begin
            amount[i*AMT_W +: AMT_W] = AMT_W'(amt_tb[i]);
        end
    endtask

    // Emitter stand-in: pulses emit_done 'amount' cycles after each load strobe.
    initial begin
        int n;
        emit_done = 1'b0;
        forever begin
            @(negedge clk);
            if (load1 && emitter_on) begin
                n = int'(emit_amt);
                repeat (n) @(posedge clk);
                #1 emit_done = 1'b1;
                @(posedge clk);
                #1 emit_done = 1'b0;
            end
        end
    end

    // Scoreboard monitor: every load strobe or ack must match the next prediction.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (RESET && (load1 || ack != '0)) begin
                if (exp_q.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("FAIL sb_unexpected: got load1=%0b ack=%0b, expected no event (cycle %0d)",
                             load1, ack, cyc);
                end else begin
                    e = exp_q.pop_front();
                    if (load1) begin
                        check("sb_is_load", 1, e.is_load);
                        check("sb_load_grant", grant_id, e.id);
                        check("sb_emit_amt", emit_amt, e.amt);
                    end else begin
                        check("sb_is_load", 0, e.is_load);
                        check("sb_ack_vec", ack, 1 << e.id);
                        check("sb_ack_grant", grant_id, e.id);
                    end
                end
            end
        end
    end

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (!busy) begin
                ok = 1'b1;
                break;
            end
        end
        check("idle_reached", ok, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_clr();
        @(posedge clk);
        #1 fault_clr = 1'b1;
        @(posedge clk);
        #1 fault_clr = 1'b0;
        @(negedge clk);
    endtask

    // One requester alone, with full latency and GAP timing checks.
    task automatic dispense_one(input int id, input int amt);
        int load_off, ack_off, oc_cnt, busy_gap, busy_idle;
        wait_idle();
        amt_tb[id] = amt;
        apply_amounts();
        if (amt != 0) push_exp(1'b1, id, amt);
        push_exp(1'b0, id, 0);
        model_ptr = id;
        req       = '0;
        req[id]   = 1'b1;
        load_off  = -1;
        ack_off   = -1;
        oc_cnt    = 0;
        busy_gap  = -1;
        busy_idle = -1;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (load1 && load_off < 0) load_off = k;
            if (out_ctrl) oc_cnt++;
            if (ack != '0 && ack_off < 0) begin
                ack_off = k;
                req     = '0;
            end
            if (ack_off >= 0 && k == ack_off + GAP) busy_gap = int'(busy);
            if (ack_off >= 0 && k == ack_off + GAP + 1) begin
                busy_idle = int'(busy);
                break;
            end
        end
        check("load_latency", load_off, (amt != 0) ? 2 : -1);
        check("ack_latency", ack_off, (amt != 0) ? amt + 3 : 1);
        check("out_ctrl_cycles", oc_cnt, (amt != 0) ? amt + 1 : 0);
        check("busy_in_gap", busy_gap, 1);
        check("busy_after_gap", busy_idle, 0);
    endtask

    // Several requesters; in hold mode requests stay up so grants keep rotating.
    task automatic run_batch(input logic [N_REQ-1:0] mask, input int n, input bit hold);
        logic [N_REQ-1:0] live;
        int p, w, got, last_ack;
        wait_idle();
        apply_amounts();
        live = mask;
        p    = model_ptr;
        for (int g = 0; g < n; g++) begin
            w = next_winner(live, p);
            if (amt_tb[w] != 0) push_exp(1'b1, w, amt_tb[w]);
            push_exp(1'b0, w, 0);
            p = w;
            if (!hold) live[w] = 1'b0;
        end
        model_ptr = p;
        req       = mask;
        got       = 0;
        last_ack  = -1;
        for (int c = 0; c < 3000 && got < n; c++) begin
            @(negedge clk);
            if (load1 && last_ack >= 0) check("ack_to_load_gap", cyc - last_ack, GAP + 3);
            if (ack != '0) begin
                got++;
                last_ack = cyc;
                if (!hold) req = req & ~ack;
                if (got == n) req = '0;
            end
        end
        check("batch_grants", got, n);
    endtask

    initial begin
        logic [N_REQ-1:0] mask;
        int lo, oc, fo;
        bit seen;

        RESET     = 1'b0;
        req       = '0;
        amount    = '0;
        estop     = 1'b0;
        fault_clr = 1'b0;
        for (int i = 0; i < N_REQ; i++) amt_tb[i] = 0;

        repeat (3) @(posedge clk);
        #1 RESET = 1'b1;
        @(negedge clk);
        check("rst_load1", load1, 0);
        check("rst_out_ctrl", out_ctrl, 0);
        check("rst_ack", ack, 0);
        check("rst_busy", busy, 0);
        check("rst_fault", fault, 0);
        check("rst_grant_id", grant_id, 0);
        check("rst_emit_amt", emit_amt, 0);

        // Contention with requests held: grants rotate 0,1,0,1.
        amt_tb[0] = 3;
        amt_tb[1] = 7;
        run_batch(2'b11, 4, 1'b1);

        dispense_one(0, 5);
        dispense_one(1, 0);

        for (int r = 0; r < 10; r++) begin
            mask = N_REQ'($urandom_range(1, (1 << N_REQ) - 1));
            for (int i = 0; i < N_REQ; i++) begin
                amt_tb[i] = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 15));
            end
            if (r % 3 == 2) run_batch(mask, int'($urandom_range(2, 5)), 1'b1);
            else            run_batch(mask, $countones(mask), 1'b0);
        end

        // Watchdog: emitter silent, out_ctrl for exactly TIMEOUT cycles, then fault.
        wait_idle();
        emitter_on = 1'b0;
        amt_tb[0]  = 9;
        apply_amounts();
        push_exp(1'b1, 0, 9);
        req = 2'b01;
        lo  = -1;
        oc  = 0;
        fo  = -1;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (load1 && lo < 0) lo = k;
            if (out_ctrl) oc++;
            if (fault) begin
                fo = k;
                break;
            end
        end
        check("to_load_latency", lo, 2);
        check("to_out_ctrl_cycles", oc, TIMEOUT);
        check("to_fault_offset", fo, 2 + TIMEOUT);
        check("to_out_ctrl_low", out_ctrl, 0);
        check("to_busy", busy, 1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("to_fault_hold", fault, 1);
        end
        @(posedge clk);
        #1 emitter_on = 1'b1;
        push_exp(1'b1, 0, 9);
        push_exp(1'b0, 0, 0);
        model_ptr = 0;
        pulse_clr();
        check("to_fault_cleared", fault, 0);
        seen = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (ack != '0) begin
                seen = 1'b1;
                req  = '0;
                break;
            end
        end
        check("to_regrant_ack", seen, 1);

        // Estop in the third RUN cycle; a late emit_done during FAULT is ignored.
        wait_idle();
        amt_tb[0] = 6;
        apply_amounts();
        push_exp(1'b1, 0, 6);
        req = 2'b01;
        seen = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (load1) begin
                seen = 1'b1;
                break;
            end
        end
        check("es_load_seen", seen, 1);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1 estop = 1'b1;
        @(negedge clk);
        check("es_run3_fault", fault, 0);
        check("es_run3_out_ctrl", out_ctrl, 1);
        @(negedge clk);
        check("es_fault", fault, 1);
        check("es_out_ctrl", out_ctrl, 0);
        req = '0;
        pulse_clr();
        check("es_clr_ignored", fault, 1);
        repeat (6) @(negedge clk);
        @(posedge clk);
        #1 estop = 1'b0;
        @(negedge clk);
        check("es_fault_persists", fault, 1);
        pulse_clr();
        check("es_fault_cleared", fault, 0);
        check("es_busy_cleared", busy, 0);

        // Reset in the middle of RUN: everything drops, no ack.
        wait_idle();
        emitter_on = 1'b0;
        amt_tb[1]  = 12;
        apply_amounts();
        push_exp(1'b1, 1, 12);
        req = 2'b10;
        seen = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (load1) begin
                seen = 1'b1;
                break;
            end
        end
        check("rr_load_seen", seen, 1);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1 RESET = 1'b0;
        req = '0;
        @(posedge clk);
        #1 RESET = 1'b1;
        @(negedge clk);
        check("rr_out_ctrl", out_ctrl, 0);
        check("rr_load1", load1, 0);
        check("rr_ack", ack, 0);
        check("rr_busy", busy, 0);
        check("rr_grant_id", grant_id, 0);
        check("rr_emit_amt", emit_amt, 0);
        model_ptr  = N_REQ - 1;
        emitter_on = 1'b1;

        amt_tb[0] = 4;
        amt_tb[1] = 2;
        run_batch(2'b11, 2, 1'b1);

        wait_idle();
        check("sb_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
